// File: rtl/fsm_capture_pkg.sv
// Shared definitions for the fsm output capture path.
//   CAP_WIDTH  : default sample width, equal to the fsm `y` width.
//   pk_state_t : packer state (low-nibble wait / high-nibble wait).
//   level_w()  : width of a 0..depth occupancy count.
package fsm_capture_pkg;

  localparam int CAP_WIDTH = 4;

  typedef enum logic {
    PK_LO = 1'b0,
    PK_HI = 1'b1
  } pk_state_t;

  // Occupancy runs 0..depth inclusive, so one bit more than the pointer.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/capture_fifo.sv
// Generic synchronous first-word-fall-through FIFO.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   flush        : synchronous clear of pointers and level (push/pop ignored)
//   push         : write request for push_data
//   accept       : push is taken this cycle (room, or a pop frees a slot)
//   pop          : consumer ready; a pop happens only while valid
//   pop_data     : head entry, combinational from mem[rd_ptr]
//   valid        : FIFO non-empty
//   level        : number of stored entries
// Handshake: a word moves out on a rising edge where valid && pop are both
// high; pop_data is held stable until that edge.
module capture_fifo
  import fsm_capture_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int PW     = $clog2(DEPTH),
  localparam int LW     = level_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              accept,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              valid,
  output logic [LW-1:0]     level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic              full;
  logic              do_pop;
  logic              do_push;

  // Full/empty come from the level count; pointers alone are ambiguous.
  assign valid    = (level != '0);
  assign full     = (level == LW'(DEPTH));
  assign do_pop   = pop & valid;
  // A same-cycle pop frees the head slot, so a push is accepted even when full.
  assign do_push  = push & (~full | do_pop);
  assign accept   = do_push;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage carries no reset; entries are only observable once written.
  always_ff @(posedge clock) begin
    if (!reset && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/nibble_capture_fifo.sv
// Packs pairs of fsm output samples into 2*WIDTH-bit words and buffers them
// in a FWFT FIFO drained over a valid/ready port.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   in_valid     : sample strobe (never stalled)
//   in_data      : sample value
//   flush        : clears packer and FIFO, keeps overflow
//   out_valid    : FIFO non-empty
//   out_ready    : consumer accepts out_data when out_valid is high
//   out_data     : head word {second sample, first sample}
//   level        : words held in the FIFO
//   overflow     : sticky, set when a completed word is dropped
//   pk_state     : packer state, for observation
// Handshake: a word transfers on a rising edge where out_valid && out_ready.
module nibble_capture_fifo
  import fsm_capture_pkg::*;
#(
  parameter  int WIDTH = CAP_WIDTH,
  parameter  int DEPTH = 8,
  localparam int LW    = level_w(DEPTH)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic [LW-1:0]      level,
  output logic               overflow,
  output pk_state_t          pk_state
);

  pk_state_t        state;
  logic [WIDTH-1:0] hold;
  logic             word_push;
  logic             accept;

  assign pk_state  = state;
  // The second sample of a pair completes a word in the same cycle.
  assign word_push = (state == PK_HI) & in_valid & ~flush;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= PK_LO;
      hold  <= '0;
    end else if (flush) begin
      state <= PK_LO;
    end else if (in_valid) begin
      if (state == PK_LO) begin
        hold  <= in_data;
        state <= PK_HI;
      end else begin
        // Return to PK_LO whether or not the word found room.
        state <= PK_LO;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (word_push && !accept) begin
      overflow <= 1'b1;
    end
  end

  capture_fifo #(
    .DATA_W (2 * WIDTH),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .push      (word_push),
    .push_data ({in_data, hold}),
    .accept    (accept),
    .pop       (out_ready),
    .pop_data  (out_data),
    .valid     (out_valid),
    .level     (level)
  );

endmodule

// File: doc/nibble_capture_fifo.md
Name: nibble_capture_fifo

Overview:
- Downstream consumer of the fsm datapath output.
- Accepts one WIDTH-bit sample per cycle when `in_valid` is high. Normally `in_data` is fsm `y` and `in_valid` is fsm `en`.
- Packs consecutive sample pairs into 2*WIDTH-bit words and buffers them in a first-word-fall-through FIFO.
- Presents the words on a valid/ready interface to the host/trace logic, so fsm output sequences can be drained without back-pressuring the fsm.

Parameters:
- WIDTH, 4, sample width (matches fsm `y`).
- DEPTH, 8, FIFO entries of 2*WIDTH bits. Must be a power of two and ≥2.

Ports:
- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high. Clears all state on the next rising edge of clock.
- in_valid  input  1  sample strobe (fsm `en`). No ready; samples are never stalled.
- in_data  input  WIDTH  sample value (fsm `y`).
- flush  input  1  synchronous clear of the packer and the FIFO. Does not clear `overflow`.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts `out_data` when `out_valid` is also high.
- out_data  output  2*WIDTH  head word: {second sample, first sample}.
- level  output  $clog2(DEPTH)+1  number of words in the FIFO.
- overflow  output  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - Packer state goes to PK_LO and the low-nibble holding register to 0.
  - rd_ptr, wr_ptr, level go to 0; out_valid = 0; overflow = 0.
  - out_data is don't-care while out_valid = 0. The bench must not check it then.
- Packer FSM, states PK_LO and PK_HI:
  - PK_LO & in_valid: store in_data in the holding register, go to PK_HI.
  - PK_HI & in_valid: form word {in_data, hold}, issue a push this cycle, go to PK_LO.
  - in_valid = 0: hold state and data.
- Pop: occurs when out_valid & out_ready. The rd_ptr increment is registered.
- Push acceptance:
  - Accepted if level < DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the word is discarded, overflow is set to 1, and the packer still returns to PK_LO (no partial retention).
- Level update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged (this includes the full case, where the push is accepted).
- Latency: the second sample of a pair, accepted at edge N, makes out_valid = 1 and out_data = the packed word after edge N (one cycle). It is visible in the cycle following the sample cycle.
- FWFT: out_data = mem[rd_ptr] combinationally. out_data is stable while out_valid & !out_ready.
- Wrap-around: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from `level`, not from pointer compare.
- Empty with out_ready high: no pop, level stays 0, no underflow.
- Flush (when reset is low):
  - Packer goes to PK_LO, pointers and level go to 0, out_valid = 0 next cycle.
  - Any sample, push, or pop in the same cycle is ignored.
  - overflow is kept.
- Reset mid-pair: the partial sample is discarded. The next accepted sample is treated as a low nibble.
- Overflow clears only on reset.

Decomposition:
- Shared package fsm_capture_pkg:
  - WIDTH default constant (4, shared with fsm y width).
  - Packer state enum {PK_LO, PK_HI}.
  - Function for the level width.
- Sub-module capture_fifo:
  - Generic sync FWFT FIFO (DATA_W, DEPTH; push/pop/flush; level).
  - Instantiated once; the top level holds the packer FSM and the overflow flag.

Test Plan:
1. Basic pair: reset low, out_ready = 0; in_valid = 1 with in_data 1 then 2.
   → one cycle after the second sample: out_valid = 1, out_data = 8'h21, level = 1.
2. Continuous stream:
   - Stimulus: in_valid = 1 for 8 cycles, data 0..7; out_ready = 1.
   - Words out, in order: 8'h10, 8'h32, 8'h54, 8'h76.
   - level never exceeds 1; overflow = 0.
3. Full/overflow:
   - Stimulus: out_ready = 0, 18 samples 0..15,0,1.
   - level = 8 after the 16th sample; overflow = 1 after the 18th.
   - Head stays 8'h10. Draining yields 8'h10…8'hFE, then out_valid = 0.
4. Simultaneous push and pop at full:
   - Stimulus: FIFO at level 8; complete a pair (3,4) in the same cycle as out_ready = 1.
   - level stays 8, overflow stays 0, and the last drained word is 8'h43.
5. Reset mid-pair and flush:
   - Sample 5, assert reset 1 cycle, then samples 6,7 → out_data = 8'h76.
   - Then 2 words queued plus flush → level = 0, out_valid = 0, overflow unchanged.
6. Gapped input:
   - Stimulus: in_valid pattern 1,0,0,1 with data 9,x,x,A.
   - Single word 8'hA9; no push on idle cycles.
